// File: rtl/ring_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ring_pkg
// Desc     : Shared types, direction constants and rotate helper for ring users
// Revision : 1.0 - initial release
// ============================================================================
package ring_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } ring_state_e;

  localparam logic DIR_RIGHT  = 1'b0;
  localparam logic DIR_LEFT   = 1'b1;
  localparam int   RING_MAX_W = 64;
  localparam int   RING_IDX_W = 6;

  // Words up to RING_MAX_W bits; only the low w bits take part in the rotation.
  function automatic logic [RING_MAX_W-1:0] ring_rotate(
    input logic [RING_MAX_W-1:0] q,
    input int                    w,
    input logic                  dir
  );
    logic [RING_MAX_W-1:0] r;
    int                    j;
    r = '0;
    for (int i = 0; i < RING_MAX_W; i++) begin
      if (i < w) begin
        j    = (dir == DIR_RIGHT) ? ((i + 1) % w) : ((i + w - 1) % w);
        r[i] = q[j[RING_IDX_W-1:0]];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ring_onehot_dec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ring_onehot_dec
// Desc     : Combinational one-hot ring word decoder: binary index + legal flag
// Revision : 1.0 - initial release
// ============================================================================
module ring_onehot_dec #(
  parameter  int WIDTH = 4,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] ring_i,
  output logic [IW-1:0]    idx_o,
  output logic             legal_o
);

  // OR of set-bit positions; only meaningful when legal_o is high.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_i[i]) idx_o = idx_o | IW'(i);
    end
  end

  assign legal_o = ($countones(ring_i) == 1);

endmodule
`default_nettype wire

// File: rtl/ring_seq_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ring_seq_monitor
// Desc     : Decodes a sampled one-hot ring word and checks its cyclic rotation.
//            Optional macro SEQ_ERR_STICKY_EN adds err_clr / err_sticky.
// Revision : 1.0 - initial release
// ============================================================================
module ring_seq_monitor
  import ring_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int DIR      = 0,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic [WIDTH-1:0]         ring_in,
`ifdef SEQ_ERR_STICKY_EN
  input  logic                     err_clr,
  output logic                     err_sticky,
`endif
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     idx_valid,
  output logic                     locked,
  output logic                     seq_err,
  output logic                     wrap,
  output logic [ERR_W-1:0]         err_count
);

  localparam int             IW         = $clog2(WIDTH);
  localparam int             CW         = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0]  LOCK_CNT_C = CW'(LOCK_CNT);
  localparam logic           DIR_BIT    = (DIR != 0) ? DIR_LEFT : DIR_RIGHT;

  ring_state_e      state_q;
  logic [WIDTH-1:0] prev_q;
  logic [CW-1:0]    cnt_q;
  logic [IW-1:0]    idx_q;
  logic             idx_valid_q;
  logic             locked_q;
  logic             seq_err_q;
  logic             wrap_q;
  logic [ERR_W-1:0] err_count_q;
  logic [ERR_W-1:0] err_count_d;
`ifdef SEQ_ERR_STICKY_EN
  logic             err_sticky_q;
`endif

  logic [IW-1:0]    w_idx;
  logic             w_legal;
  logic [WIDTH-1:0] w_rot;
  logic             w_good;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_err_ev;
  logic             w_wrap_ev;

  ring_onehot_dec #(.WIDTH(WIDTH)) u_dec (
    .ring_i  (ring_in),
    .idx_o   (w_idx),
    .legal_o (w_legal)
  );

  // prev_q only ever holds a legal word outside SEARCH.
  assign w_rot     = WIDTH'(ring_rotate(RING_MAX_W'(prev_q), WIDTH, DIR_BIT));
  assign w_good    = w_legal && (state_q != SEARCH) && (ring_in == w_rot);
  assign w_cnt_inc = cnt_q + 1'b1;
  assign w_err_ev  = en && (state_q == LOCKED) && !w_good;
  assign w_wrap_ev = en && w_good && (w_idx == '0) &&
                     ((state_q == LOCKED) ||
                      ((state_q == TRACK) && (w_cnt_inc == LOCK_CNT_C)));

  // A clear and an increment in the same cycle leaves the count at one.
  always_comb begin
    err_count_d = err_count_q;
`ifdef SEQ_ERR_STICKY_EN
    if (err_clr) err_count_d = '0;
`endif
    if (w_err_ev && (err_count_d != '1)) err_count_d = err_count_d + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SEARCH;
      prev_q       <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      locked_q     <= 1'b0;
      seq_err_q    <= 1'b0;
      wrap_q       <= 1'b0;
      err_count_q  <= '0;
`ifdef SEQ_ERR_STICKY_EN
      err_sticky_q <= 1'b0;
`endif
    end else begin
      seq_err_q   <= w_err_ev;
      wrap_q      <= w_wrap_ev;
      err_count_q <= err_count_d;
`ifdef SEQ_ERR_STICKY_EN
      if (w_err_ev)     err_sticky_q <= 1'b1;
      else if (err_clr) err_sticky_q <= 1'b0;
`endif
      if (en) begin
        idx_valid_q <= w_legal;
        if (w_legal) idx_q <= w_idx;
        if (w_good) begin
          prev_q <= ring_in;
          if (state_q == TRACK) begin
            cnt_q <= w_cnt_inc;
            if (w_cnt_inc == LOCK_CNT_C) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
        end else if (w_legal) begin
          prev_q   <= ring_in;
          cnt_q    <= '0;
          state_q  <= TRACK;
          locked_q <= 1'b0;
        end else begin
          cnt_q    <= '0;
          state_q  <= SEARCH;
          locked_q <= 1'b0;
        end
      end
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign locked    = locked_q;
  assign seq_err   = seq_err_q;
  assign wrap      = wrap_q;
  assign err_count = err_count_q;
`ifdef SEQ_ERR_STICKY_EN
  assign err_sticky = err_sticky_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ring_seq_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ring_seq_monitor
// Desc     : Self-checking bench; DIR=0 and DIR=1 instances share the stimulus
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_seq_monitor;

  localparam int W  = 4;
  localparam int LK = 3;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       en      = 1'b0;
  logic [3:0] ring_in = 4'b0000;

  logic [1:0] idx0, idx1;
  logic       v0, v1, l0, l1, s0, s1, wr0, wr1;
  logic [7:0] e0, e1;
`ifdef SEQ_ERR_STICKY_EN
  logic       err_clr = 1'b0;
  logic       st0, st1;
`endif

  int n_vec = 0;
  int n_bad = 0;

  int m_run [2];
  int m_prev[2];
  int m_idx [2];
  int m_err [2];
  bit m_valid[2], m_lock[2], m_seq[2], m_wrap[2], m_sticky[2];

  always #5 clk = ~clk;

  ring_seq_monitor #(.WIDTH(4), .DIR(0), .LOCK_CNT(3), .ERR_W(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .en(en), .ring_in(ring_in),
`ifdef SEQ_ERR_STICKY_EN
    .err_clr(err_clr), .err_sticky(st0),
`endif
    .idx(idx0), .idx_valid(v0), .locked(l0), .seq_err(s0), .wrap(wr0), .err_count(e0)
  );

  ring_seq_monitor #(.WIDTH(4), .DIR(1), .LOCK_CNT(3), .ERR_W(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .ring_in(ring_in),
`ifdef SEQ_ERR_STICKY_EN
    .err_clr(err_clr), .err_sticky(st1),
`endif
    .idx(idx1), .idx_valid(v1), .locked(l1), .seq_err(s1), .wrap(wr1), .err_count(e1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = -1; m_prev[d] = 0; m_idx[d] = 0; m_err[d] = 0;
      m_valid[d] = 0; m_lock[d] = 0; m_seq[d] = 0; m_wrap[d] = 0; m_sticky[d] = 0;
    end
  endfunction

  // m_run: length of the current chain of good rotations (-1 = no legal seed).
  function automatic void model_step(input int d, input bit e, input logic [3:0] w, input bit clr);
    int p;
    bit legal, good, was;
    m_seq[d]  = 0;
    m_wrap[d] = 0;
    if (e) begin
      legal = ($countones(w) == 1);
      p = 0;
      for (int i = 0; i < W; i++) if (w[i]) p = i;
      was  = (m_run[d] >= LK);
      good = legal && (m_run[d] >= 0) &&
             (p == ((d == 0) ? (m_prev[d] + W - 1) % W : (m_prev[d] + 1) % W));
      if (!legal)    m_run[d] = -1;
      else if (good) m_run[d] = m_run[d] + 1;
      else           m_run[d] = 0;
      if (legal) begin
        m_prev[d] = p;
        m_idx[d]  = p;
      end
      m_valid[d] = legal;
      m_seq[d]   = was && !good;
      m_wrap[d]  = good && (p == 0) && (m_run[d] >= LK);
    end
    if (clr) m_err[d] = 0;
    if (m_seq[d] && m_err[d] < 255) m_err[d] = m_err[d] + 1;
    if (m_seq[d])  m_sticky[d] = 1;
    else if (clr)  m_sticky[d] = 0;
    m_lock[d] = (m_run[d] >= LK);
  endfunction

  task automatic cmp_model(input int d, input logic [1:0] i, input logic v, input logic l,
                           input logic s, input logic wr, input logic [7:0] e);
    chk($sformatf("dut%0d.idx", d),       32'(i),  32'(m_idx[d]));
    chk($sformatf("dut%0d.idx_valid", d), 32'(v),  32'(m_valid[d]));
    chk($sformatf("dut%0d.locked", d),    32'(l),  32'(m_lock[d]));
    chk($sformatf("dut%0d.seq_err", d),   32'(s),  32'(m_seq[d]));
    chk($sformatf("dut%0d.wrap", d),      32'(wr), 32'(m_wrap[d]));
    chk($sformatf("dut%0d.err_count", d), 32'(e),  32'(m_err[d]));
  endtask

  task automatic step(input bit e, input logic [3:0] w, input bit clr);
    @(negedge clk);
    en      = e;
    ring_in = w;
`ifdef SEQ_ERR_STICKY_EN
    err_clr = clr;
`endif
    @(posedge clk);
    model_step(0, e, w, clr);
    model_step(1, e, w, clr);
    #1;
    cmp_model(0, idx0, v0, l0, s0, wr0, e0);
    cmp_model(1, idx1, v1, l1, s1, wr1, e1);
`ifdef SEQ_ERR_STICKY_EN
    chk("dut0.err_sticky", 32'(st0), 32'(m_sticky[0]));
    chk("dut1.err_sticky", 32'(st1), 32'(m_sticky[1]));
`endif
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".idx"},   32'(idx0) | 32'(idx1), 0);
    chk({tag, ".valid"}, 32'(v0)   | 32'(v1),   0);
    chk({tag, ".locked"},32'(l0)   | 32'(l1),   0);
    chk({tag, ".seq"},   32'(s0)   | 32'(s1),   0);
    chk({tag, ".wrap"},  32'(wr0)  | 32'(wr1),  0);
    chk({tag, ".err"},   32'(e0)   | 32'(e1),   0);
  endtask

  typedef struct {
    bit         en;
    logic [3:0] ring;
    int         idx;
    bit         valid;
    bit         lock;
    bit         serr;
    bit         wrap;
    int         err;
  } vec_t;

  vec_t tbl[25];

  initial begin
    logic [3:0] cur;
    logic [3:0] nw;
    int         r, k, dsel;
    bit         e;

    // en, ring, idx, valid, locked, seq_err, wrap, err_count (after the edge)
    tbl[0]  = '{1'b1, 4'b0001, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 4'b1000, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 4'b0100, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b1, 4'b0010, 1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b1, 4'b0001, 0, 1'b1, 1'b1, 1'b0, 1'b1, 0};
    tbl[5]  = '{1'b1, 4'b0110, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[6]  = '{1'b1, 4'b0001, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[7]  = '{1'b1, 4'b1000, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[8]  = '{1'b1, 4'b0100, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[9]  = '{1'b1, 4'b0010, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[10] = '{1'b1, 4'b0001, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1};
    tbl[11] = '{1'b1, 4'b1000, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[12] = '{1'b1, 4'b0100, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[13] = '{1'b1, 4'b0100, 2, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    tbl[14] = '{1'b1, 4'b0010, 1, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[15] = '{1'b1, 4'b0001, 0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[16] = '{1'b1, 4'b1000, 3, 1'b1, 1'b1, 1'b0, 1'b0, 2};
    tbl[17] = '{1'b0, 4'b0110, 3, 1'b1, 1'b1, 1'b0, 1'b0, 2};
    tbl[18] = '{1'b0, 4'b0000, 3, 1'b1, 1'b1, 1'b0, 1'b0, 2};
    tbl[19] = '{1'b1, 4'b0100, 2, 1'b1, 1'b1, 1'b0, 1'b0, 2};
    tbl[20] = '{1'b1, 4'b0010, 1, 1'b1, 1'b1, 1'b0, 1'b0, 2};
    tbl[21] = '{1'b1, 4'b0001, 0, 1'b1, 1'b1, 1'b0, 1'b1, 2};
    tbl[22] = '{1'b1, 4'b0000, 0, 1'b0, 1'b0, 1'b1, 1'b0, 3};
    tbl[23] = '{1'b1, 4'b0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 3};
    tbl[24] = '{1'b0, 4'b0001, 0, 1'b0, 1'b0, 1'b0, 1'b0, 3};

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    for (int t = 0; t < 25; t++) begin
      step(tbl[t].en, tbl[t].ring, 1'b0);
      chk($sformatf("tbl%0d.idx", t),    32'(idx0), 32'(tbl[t].idx));
      chk($sformatf("tbl%0d.valid", t),  32'(v0),   32'(tbl[t].valid));
      chk($sformatf("tbl%0d.locked", t), 32'(l0),   32'(tbl[t].lock));
      chk($sformatf("tbl%0d.seq", t),    32'(s0),   32'(tbl[t].serr));
      chk($sformatf("tbl%0d.wrap", t),   32'(wr0),  32'(tbl[t].wrap));
      chk($sformatf("tbl%0d.err", t),    32'(e0),   32'(tbl[t].err));
    end

    // Left-rotating sequence: dut1 locks and wraps, dut0 never locks.
    step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b0010, 1'b0);
    step(1'b1, 4'b0100, 1'b0);
    step(1'b1, 4'b1000, 1'b0);
    chk("dir1.locked4", 32'(l1), 1);
    chk("dir0.locked4", 32'(l0), 0);
    step(1'b1, 4'b0001, 1'b0);
    chk("dir1.wrap", 32'(wr1), 1);
    chk("dir1.locked5", 32'(l1), 1);
    chk("dir0.seq", 32'(s0), 0);
    chk("dir0.locked5", 32'(l0), 0);
    chk("dir0.err", 32'(e0), 3);

    // Reset asserted between edges while dut1 is locked.
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    for (int n = 0; n < 260; n++) begin
      step(1'b1, 4'b0001, 1'b0);
      step(1'b1, 4'b1000, 1'b0);
      step(1'b1, 4'b0100, 1'b0);
      step(1'b1, 4'b0010, 1'b0);
      step(1'b1, 4'b0000, 1'b0);
    end
    chk("sat.err_count", 32'(e0), 255);

`ifdef SEQ_ERR_STICKY_EN
    step(1'b1, 4'b0001, 1'b0);
    step(1'b1, 4'b1000, 1'b0);
    step(1'b1, 4'b0100, 1'b0);
    step(1'b1, 4'b0010, 1'b0);
    step(1'b1, 4'b0000, 1'b1);
    chk("clr_vs_err.err_count", 32'(e0), 1);
    chk("clr_vs_err.sticky", 32'(st0), 1);
    step(1'b1, 4'b0001, 1'b1);
    chk("clr.err_count", 32'(e0), 0);
    chk("clr.sticky", 32'(st0), 0);
`endif

    cur  = 4'b0001;
    dsel = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) dsel = 1 - dsel;
      r = $urandom_range(0, 99);
      k = 0;
      for (int i = 0; i < W; i++) if (cur[i]) k = i;
      if (r < 70)      nw = 4'(1 << ((dsel == 0) ? (k + W - 1) % W : (k + 1) % W));
      else if (r < 80) nw = cur;
      else if (r < 90) nw = 4'(1 << $urandom_range(0, W - 1));
      else             nw = 4'($urandom_range(0, 15));
      e = ($urandom_range(0, 99) < 85);
      if (e && $countones(nw) == 1) cur = nw;
`ifdef SEQ_ERR_STICKY_EN
      step(e, nw, ($urandom_range(0, 99) < 3));
`else
      step(e, nw, 1'b0);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
